// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic {
        MDU_MUL = 1'b0,
        MDU_DIV = 1'b1
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Number of RUN cycles needed to retire data_w bits at step bits per cycle.
    function automatic int iter_count(input int data_w, input int step);
        return data_w / step;
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module mdu_divstep #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] div_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // rem_i < div_i always holds, so the top bit of trial is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, div_i};
        q_o     = ~trial[DATA_W];
        rem_o   = q_o ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/iter_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// magnitude arithmetic with a final sign-fix cycle.
module iter_muldiv
    import mdu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 2,
    parameter int DIV_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  mdu_op_t           op,
    input  logic              sign,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              dbz,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MUL_N = iter_count(DATA_W, MUL_STEP);
    localparam int DIV_N = iter_count(DATA_W, DIV_STEP);
    localparam int CNT_W = $clog2(DATA_W + 1);

    if (DATA_W < 8 || (DATA_W % 2) != 0) begin : g_bad_data_w
        $error("iter_muldiv: DATA_W must be even and at least 8");
    end
    if ((DATA_W % MUL_STEP) != 0 || (DATA_W % DIV_STEP) != 0) begin : g_bad_step
        $error("iter_muldiv: MUL_STEP and DIV_STEP must divide DATA_W");
    end

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic s);
        return (s && v[DATA_W-1]) ? -v : v;
    endfunction

    mdu_state_t        state_q, state_d;
    mdu_op_t           op_q, op_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic              accept;
    logic              is_dz;
    logic              res_we;
    logic [DATA_W-1:0] mag_a, mag_b;

    logic [DATA_W+MUL_STEP-1:0] mul_sum;
    logic [2*DATA_W-1:0]        mul_shift;
    logic [2*DATA_W-1:0]        mul_mag;
    logic [2*DATA_W-1:0]        mul_res;
    logic [DATA_W-1:0]          res_hi, res_lo;

    logic [DATA_W-1:0]   rem_chain [DIV_STEP+1];
    logic [DIV_STEP-1:0] div_q;

    // Requests are only taken in IDLE and not while the previous done is still showing.
    assign accept = (state_q == IDLE) && start && !flush && !done_q;
    assign is_dz  = (op == MDU_DIV) && (src_b == '0);
    assign mag_a  = magnitude(src_a, sign);
    assign mag_b  = magnitude(src_b, sign);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = is_dz ? FIX : RUN;
                RUN:     if (cnt_q == '0) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done_d = (state_q == FIX) && !flush;
        dbz_d  = (state_q == FIX) && !flush && dz_q;
        res_we = (state_q == FIX) && !flush && !dz_q;
    end

    // Multiply: add multiplicand x low multiplier bits into the upper half, then shift right.
    always_comb begin
        mul_sum = {{MUL_STEP{1'b0}}, acc_hi_q};
        for (int j = 0; j < MUL_STEP; j++) begin
            if (acc_lo_q[j]) begin
                mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, opnd_q} << j);
            end
        end
        mul_shift = (2*DATA_W)'({mul_sum, acc_lo_q} >> MUL_STEP);
    end

    assign rem_chain[0] = acc_hi_q;

    for (genvar k = 0; k < DIV_STEP; k++) begin : g_div
        mdu_divstep #(.DATA_W(DATA_W)) u_divstep (
            .rem_i (rem_chain[k]),
            .bit_i (acc_lo_q[DATA_W-1-k]),
            .div_i (opnd_q),
            .rem_o (rem_chain[k+1]),
            .q_o   (div_q[DIV_STEP-1-k])
        );
    end

    // Sign fix: the remainder follows the dividend, the quotient/product the operand xor.
    always_comb begin
        mul_mag = {acc_hi_q, acc_lo_q};
        mul_res = neg_res_q ? -mul_mag : mul_mag;
        if (op_q == MDU_MUL) begin
            res_hi = mul_res[2*DATA_W-1:DATA_W];
            res_lo = mul_res[DATA_W-1:0];
        end else begin
            res_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
            res_lo = neg_res_q ? -acc_lo_q : acc_lo_q;
        end
    end

    always_comb begin
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        if (accept) begin
            op_d      = op;
            neg_res_d = sign && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            neg_rem_d = sign && src_a[DATA_W-1];
            dz_d      = is_dz;
            cnt_d     = (op == MDU_MUL) ? CNT_W'(MUL_N - 1) : CNT_W'(DIV_N - 1);
            opnd_d    = (op == MDU_MUL) ? mag_a : mag_b;
            acc_hi_d  = '0;
            acc_lo_d  = (op == MDU_MUL) ? mag_b : mag_a;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == MDU_MUL) begin
                acc_hi_d = mul_shift[2*DATA_W-1:DATA_W];
                acc_lo_d = mul_shift[DATA_W-1:0];
            end else begin
                acc_hi_d = rem_chain[DIV_STEP];
                acc_lo_d = (acc_lo_q << DIV_STEP) | DATA_W'(div_q);
            end
        end
    end

    // A result write on the same edge overrides a direct MTHI/MTLO write.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= MDU_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Randomised bench for iter_muldiv against a plain-arithmetic HI/LO model.
module tb_iter_muldiv;
    import mdu_pkg::*;

    localparam int W  = 32;
    localparam int MS = 2;
    localparam int DS = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_r, sign_r, flush_r, hi_we_r, lo_we_r;
    mdu_op_t     op_r;
    logic [W-1:0] a_r, b_r, wdata_r;
    logic        busy, done, dbz;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] ref_hi, ref_lo;

    always #5 clk = ~clk;

    iter_muldiv #(.DATA_W(W), .MUL_STEP(MS), .DIV_STEP(DS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_r),
        .op    (op_r),
        .sign  (sign_r),
        .src_a (a_r),
        .src_b (b_r),
        .flush (flush_r),
        .hi_we (hi_we_r),
        .lo_we (lo_we_r),
        .wdata (wdata_r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input mdu_op_t o, input logic sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] eh,
                         output logic [W-1:0] el, output bit edz);
        longint sa, sb, p, q, r;
        sa  = sg ? longint'($signed(a)) : longint'({32'h0, a});
        sb  = sg ? longint'($signed(b)) : longint'({32'h0, b});
        edz = 1'b0;
        if (o == MDU_MUL) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (b == '0) begin
            edz = 1'b1;
            eh  = ref_hi;
            el  = ref_lo;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        return $urandom;
    endfunction

    task automatic do_op(input mdu_op_t o, input logic sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input string tag, input int inj_cyc,
                         input bit mtlo_exit, input bit start_at_done);
        logic [W-1:0] eh, el;
        bit edz;
        int expl, c, lat, nb;
        model(o, sg, a, b, eh, el, edz);
        expl = edz ? 2 : (((o == MDU_MUL) ? W / MS : W / DS) + 2);
        op_r = o; sign_r = sg; a_r = a; b_r = b; start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0; a_r = $urandom; b_r = $urandom;
        c = 1; lat = 0; nb = 0;
        forever begin
            if (busy) nb++;
            if (done) begin lat = c; break; end
            if (c >= 200) break;
            if (inj_cyc != 0 && c == inj_cyc) begin
                start_r = 1'b1;
                op_r    = (o == MDU_MUL) ? MDU_DIV : MDU_MUL;
                a_r     = $urandom; b_r = $urandom;
            end else begin
                start_r = 1'b0;
            end
            if (mtlo_exit && c == expl - 1) begin lo_we_r = 1'b1; wdata_r = 32'hAA; end
            @(posedge clk); #1;
            c++;
        end
        start_r = 1'b0;
        chk({tag, "/latency"}, 64'(lat), 64'(expl));
        chk({tag, "/busy_cycles"}, 64'(nb), 64'(expl - 1));
        chk({tag, "/hi"}, 64'(hi), 64'(eh));
        chk({tag, "/lo"}, 64'(lo), 64'(el));
        chk({tag, "/dbz"}, 64'(dbz), 64'(edz));
        if (start_at_done) begin
            start_r = 1'b1; op_r = MDU_MUL; a_r = $urandom; b_r = $urandom;
        end
        @(posedge clk); #1;
        start_r = 1'b0;
        chk({tag, "/done_width"}, 64'(done), 64'(0));
        if (start_at_done) chk({tag, "/start_at_done_ignored"}, 64'(busy), 64'(0));
        if (mtlo_exit) begin
            lo_we_r = 1'b0;
            chk({tag, "/mtlo_after"}, 64'(lo), 64'(32'hAA));
            el = 32'hAA;
        end
        ref_hi = eh;
        ref_lo = el;
    endtask

    initial begin
        int c, seen;
        rst_n = 1'b0; start_r = 1'b0; sign_r = 1'b0; flush_r = 1'b0;
        hi_we_r = 1'b0; lo_we_r = 1'b0; op_r = MDU_MUL;
        a_r = '0; b_r = '0; wdata_r = '0;
        ref_hi = '0; ref_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/busy", 64'(busy), 64'(0));
        chk("rst/done", 64'(done), 64'(0));
        chk("rst/dbz", 64'(dbz), 64'(0));
        chk("rst/hi", 64'(hi), 64'(0));
        chk("rst/lo", 64'(lo), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(MDU_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_uu_max", 0, 0, 0);
        chk("mul_uu_max/hi_k", 64'(hi), 64'(32'hFFFF_FFFE));
        chk("mul_uu_max/lo_k", 64'(lo), 64'(32'h0000_0001));
        do_op(MDU_MUL, 1'b1, -32'sd3, 32'd7, "mul_s", 0, 0, 0);
        chk("mul_s/hi_k", 64'(hi), 64'(32'hFFFF_FFFF));
        chk("mul_s/lo_k", 64'(lo), 64'(32'hFFFF_FFEB));
        do_op(MDU_DIV, 1'b1, -32'sd7, 32'd2, "div_s", 0, 0, 0);
        chk("div_s/lo_k", 64'(lo), 64'(32'hFFFF_FFFD));
        chk("div_s/hi_k", 64'(hi), 64'(32'hFFFF_FFFF));
        do_op(MDU_DIV, 1'b0, 32'd100, 32'd7, "div_u", 0, 0, 0);
        chk("div_u/lo_k", 64'(lo), 64'(32'hE));
        chk("div_u/hi_k", 64'(hi), 64'(32'h2));
        do_op(MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf_s", 0, 0, 0);
        chk("div_ovf_s/lo_k", 64'(lo), 64'(32'h8000_0000));
        chk("div_ovf_s/hi_k", 64'(hi), 64'(32'h0));
        do_op(MDU_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf_u", 0, 0, 0);
        chk("div_ovf_u/lo_k", 64'(lo), 64'(32'h0));
        chk("div_ovf_u/hi_k", 64'(hi), 64'(32'h8000_0000));

        hi_we_r = 1'b1; wdata_r = 32'h1234;
        @(posedge clk); #1;
        hi_we_r = 1'b0; lo_we_r = 1'b1; wdata_r = 32'h5678;
        @(posedge clk); #1;
        lo_we_r = 1'b0;
        chk("mthi", 64'(hi), 64'(32'h1234));
        chk("mtlo", 64'(lo), 64'(32'h5678));
        ref_hi = 32'h1234; ref_lo = 32'h5678;
        do_op(MDU_DIV, 1'b1, $urandom, 32'h0, "dbz", 0, 0, 0);
        chk("dbz/hi_kept", 64'(hi), 64'(32'h1234));
        chk("dbz/lo_kept", 64'(lo), 64'(32'h5678));

        hi_we_r = 1'b1; lo_we_r = 1'b1; wdata_r = 32'hCAFE;
        @(posedge clk); #1;
        hi_we_r = 1'b0; lo_we_r = 1'b0;
        chk("mt_both/hi", 64'(hi), 64'(32'hCAFE));
        chk("mt_both/lo", 64'(lo), 64'(32'hCAFE));
        ref_hi = 32'hCAFE; ref_lo = 32'hCAFE;

        do_op(MDU_MUL, 1'b1, $urandom, $urandom, "start_while_busy", 5, 0, 0);
        do_op(MDU_DIV, 1'b0, $urandom, 32'd13, "start_at_done", 0, 0, 1);
        do_op(MDU_MUL, 1'b0, 32'd12345, 32'd6789, "mtlo_at_exit", 0, 1, 0);

        // Flush in the middle of a multiply.
        op_r = MDU_MUL; sign_r = 1'b0; a_r = $urandom; b_r = $urandom; start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        c = 1;
        while (c < 10) begin @(posedge clk); #1; c++; end
        chk("flush/busy_before", 64'(busy), 64'(1));
        flush_r = 1'b1;
        @(posedge clk); #1;
        flush_r = 1'b0;
        chk("flush/busy_after", 64'(busy), 64'(0));
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        chk("flush/no_done", 64'(seen), 64'(0));
        chk("flush/hi_kept", 64'(hi), 64'(ref_hi));
        chk("flush/lo_kept", 64'(lo), 64'(ref_lo));

        // Flush and start together: flush wins.
        op_r = MDU_DIV; a_r = 32'd50; b_r = 32'd5; start_r = 1'b1; flush_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0; flush_r = 1'b0;
        chk("flush_start/busy", 64'(busy), 64'(0));
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        chk("flush_start/no_done", 64'(seen), 64'(0));

        for (int i = 0; i < 50; i++) begin
            do_op(($urandom_range(1) == 1) ? MDU_DIV : MDU_MUL, 1'($urandom_range(1)),
                  pick(), pick(), $sformatf("rand%0d", i), 0, 0, 0);
        end

        // Asynchronous reset in the middle of a run.
        op_r = MDU_MUL; sign_r = 1'b1; a_r = $urandom; b_r = $urandom; start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/busy", 64'(busy), 64'(0));
        chk("rst_mid/done", 64'(done), 64'(0));
        chk("rst_mid/dbz", 64'(dbz), 64'(0));
        chk("rst_mid/hi", 64'(hi), 64'(0));
        chk("rst_mid/lo", 64'(lo), 64'(0));
        ref_hi = '0; ref_lo = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(MDU_DIV, 1'b1, 32'hFFFF_FF9C, 32'd7, "after_rst", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage; successor to the single-cycle ALU's hand-off to a fixed multiplier/divider.
- Owns the HI/LO architectural registers.
- Accepts MUL/DIV requests with a start/busy/done handshake and iterates a configurable number of bits per cycle.
- Supports signed/unsigned operation, MTHI/MTLO writes, pipeline flush and divide-by-zero flagging.

Parameters:
- DATA_W, 32, operand/HI/LO width; must be even and ≥8.
- MUL_STEP, 2, multiplier bits retired per cycle (shift-add); must divide DATA_W.
- DIV_STEP, 1, quotient bits retired per cycle (restoring); must divide DATA_W.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request valid; sampled only in IDLE
- op  in  1  mdu_op_t: MDU_MUL=0, MDU_DIV=1
- sign  in  1  1=signed, 0=unsigned
- src_a  in  DATA_W  multiplicand / dividend
- src_b  in  DATA_W  multiplier / divisor
- flush  in  1  cancel in-flight operation
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  DATA_W  MTHI/MTLO data
- busy  out  1  operation in flight (RUN or FIX)
- done  out  1  one-cycle completion pulse
- dbz  out  1  divide-by-zero, valid only while done=1
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, dbz=0, hi=0, lo=0; counter and working registers cleared.
- States: IDLE, RUN, FIX.
- IDLE:
  - On start=1 and flush=0: latch op and sign; latch |src_a| and |src_b| (magnitudes if sign=1, else raw); record result-sign flags; load counter.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, DIV with src_b=0: no iteration. Go to FIX with the dz flag set. At FIX exit: done=1, dbz=1, HI/LO unchanged.
- RUN, MUL: each cycle adds (multiplicand × next MUL_STEP bits) into a 2·DATA_W accumulator. DATA_W/MUL_STEP cycles.
- RUN, DIV: each cycle performs DIV_STEP restoring steps producing quotient bits. DATA_W/DIV_STEP cycles.
- RUN exit: when the counter reaches its last step, go to FIX.
- FIX: apply sign correction.
  - MUL: negate the full 2·DATA_W product if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - At the edge leaving FIX: write HI/LO (MUL: HI=upper, LO=lower; DIV: LO=quotient, HI=remainder); done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: start is sampled in cycle 0; done and the new HI/LO are visible in cycle N+2, where N=DATA_W/STEP. Divide-by-zero: cycle 2.
- start while busy=1 or done=1 is ignored (no queueing).
- flush=1 in any state:
  - Next state is IDLE; busy=0; no done; HI/LO unchanged.
  - If flush and start arrive together, flush wins.
  - If flush coincides with FIX exit, the write is suppressed.
- hi_we/lo_we:
  - Take effect at the next edge in any state.
  - If a FIX-exit write lands on the same edge, the FIX result wins for that register.
  - hi_we and lo_we may both be asserted; wdata goes to both.
- Overflow case: signed MIN/−1 gives quotient 0x80..0 (wraps) and remainder 0, with no exception.
- All arithmetic is modulo 2^DATA_W per result half.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package mdu_pkg holds:
  - mdu_op_t enum
  - mdu_state_t enum {IDLE, RUN, FIX}
  - MDU_MUL and MDU_DIV constants
  - a function for the iteration count given DATA_W and step
- One natural sub-module: mdu_divstep, a combinational single restoring-division step (partial remainder, divisor → next remainder, quotient bit). It is instantiated DIV_STEP times in a chain.

Test Plan:
- Unsigned MUL 0xFFFFFFFF×0xFFFFFFFF (MUL_STEP=2) → HI=0xFFFFFFFE, LO=0x00000001; done in cycle 18; busy high cycles 1–17.
- Signed MUL −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; signed DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; unsigned DIV 100/7 → LO=0xE, HI=0x2, done in cycle 34.
- Signed DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0; unsigned DIV of the same operands → LO=0, HI=0x80000000.
- DIV by 0 with HI=0x1234, LO=0x5678 preloaded via MTHI/MTLO → done in cycle 2, dbz=1, HI/LO unchanged.
- flush in cycle 10 of a MUL → busy=0 in cycle 11, no done, prior HI/LO kept; a second start in cycle 5 of another op is ignored; rst_n low mid-RUN → all outputs 0 immediately.
- lo_we with wdata=0xAA on the FIX-exit edge → LO holds the op result. lo_we one cycle later → LO=0xAA.
